// File: rtl/iiitb_tlc_pkg.sv
// Shared lamp/state encodings and approach count for the four-way phase arbiter.
package iiitb_tlc_pkg;
  localparam int N_APP = 4;
  localparam int APP_W = 2;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2
  } state_e;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  // Only the current approach ever shows a non-red lamp.
  function automatic logic [3*N_APP-1:0] f_lights(input state_e st, input logic [APP_W-1:0] cur);
    logic [3*N_APP-1:0] l;
    for (int i = 0; i < N_APP; i++) begin
      l[3*i +: 3] = LAMP_RED;
      if (i == int'(cur)) begin
        if (st == ST_GREEN)       l[3*i +: 3] = LAMP_GRN;
        else if (st == ST_YELLOW) l[3*i +: 3] = LAMP_YEL;
      end
    end
    return l;
  endfunction
endpackage

// File: rtl/iiitb_tlc_rr_pick.sv
// Round-robin pick: first set bit of mask scanning upward from start, wrapping.
module iiitb_tlc_rr_pick
  import iiitb_tlc_pkg::*;
(
  input  logic [N_APP-1:0] mask,
  input  logic [APP_W-1:0] start,
  output logic [APP_W-1:0] winner,
  output logic             any
);
  // Scan from the far end so the closest hit to start is written last.
  always_comb begin
    winner = start;
    for (int k = N_APP-1; k >= 0; k--) begin
      if (mask[start + APP_W'(k)]) winner = start + APP_W'(k);
    end
  end

  assign any = |mask;
endmodule

// File: rtl/iiitb_tlc_phase_arb.sv
// Four-approach traffic phase arbiter: green/yellow/all-red sequencing with
// round-robin handoff, min/max green, and emergency preemption.
module iiitb_tlc_phase_arb
  import iiitb_tlc_pkg::*;
#(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 12,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic [N_APP-1:0]     req,
  input  logic                 emg,
  input  logic [APP_W-1:0]     emg_id,
  output logic [3*N_APP-1:0]   light,
  output logic [N_APP-1:0]     gnt,
  output logic [1:0]           phase
);
  localparam int TMAX0 = (GREEN_MAX > YELLOW_T) ? GREEN_MAX : YELLOW_T;
  localparam int TMAX  = (TMAX0 > ALLRED_T) ? TMAX0 : ALLRED_T;
  localparam int TW    = ($clog2(TMAX) < 1) ? 1 : $clog2(TMAX);

  localparam logic [TW-1:0] T_GMIN = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] T_GMAX = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] T_YEL  = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] T_AR   = TW'(ALLRED_T - 1);

  state_e           r_state, w_state;
  logic [APP_W-1:0] r_cur, w_cur, r_nxt, w_nxt;
  logic [TW-1:0]    r_tmr, w_tmr;

  logic [N_APP-1:0] w_mask;
  logic [APP_W-1:0] w_win;
  logic             w_other, w_req_cur, w_sat;

  assign w_mask    = req & ~(N_APP'(1) << r_cur);
  assign w_req_cur = req[r_cur];
  assign w_sat     = (r_tmr == T_GMAX);

  iiitb_tlc_rr_pick u_pick (
    .mask   (w_mask),
    .start  (r_cur + APP_W'(1)),
    .winner (w_win),
    .any    (w_other)
  );

  always_comb begin
    w_state = r_state;
    w_cur   = r_cur;
    w_nxt   = r_nxt;
    w_tmr   = r_tmr;
    case (r_state)
      ST_GREEN: begin
        if (emg && emg_id != r_cur) begin
          // Preempt bypasses tick and minimum green.
          w_state = ST_YELLOW;
          w_nxt   = emg_id;
          w_tmr   = '0;
        end else if (tick) begin
          if (!emg && w_other && r_tmr >= T_GMIN && (!w_req_cur || w_sat)) begin
            w_state = ST_YELLOW;
            w_nxt   = w_win;
            w_tmr   = '0;
          end else if (!w_sat) begin
            w_tmr = r_tmr + TW'(1);
          end
        end
      end
      ST_YELLOW: begin
        if (emg) w_nxt = emg_id;
        if (tick) begin
          if (r_tmr == T_YEL) begin
            w_state = ST_ALLRED;
            w_tmr   = '0;
          end else begin
            w_tmr = r_tmr + TW'(1);
          end
        end
      end
      ST_ALLRED: begin
        if (emg) w_nxt = emg_id;
        if (tick) begin
          if (r_tmr == T_AR) begin
            w_state = ST_GREEN;
            w_cur   = w_nxt;
            w_tmr   = '0;
          end else begin
            w_tmr = r_tmr + TW'(1);
          end
        end
      end
      default: begin
        w_state = ST_ALLRED;
        w_tmr   = '0;
      end
    endcase
  end

  // Outputs are registered from next-state so they line up with r_state/r_cur.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ALLRED;
      r_cur   <= '0;
      r_nxt   <= '0;
      r_tmr   <= '0;
      light   <= {N_APP{LAMP_RED}};
      gnt     <= '0;
      phase   <= ST_ALLRED;
    end else begin
      r_state <= w_state;
      r_cur   <= w_cur;
      r_nxt   <= w_nxt;
      r_tmr   <= w_tmr;
      light   <= f_lights(w_state, w_cur);
      gnt     <= (w_state == ST_GREEN) ? (N_APP'(1) << w_cur) : '0;
      phase   <= w_state;
    end
  end
endmodule

// File: tb/tb_iiitb_tlc_phase_arb.sv
// Segment table drives the arbiter; expected phase/gnt/light go through a scoreboard queue.
module tb_iiitb_tlc_phase_arb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic        emg = 1'b0;
  logic [1:0]  emg_id = 2'd0;
  logic [11:0] light;
  logic [3:0]  gnt;
  logic [1:0]  phase;

  localparam logic [1:0] G = 2'd0, Y = 2'd1, AR = 2'd2;

  iiitb_tlc_phase_arb dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .req(req), .emg(emg), .emg_id(emg_id),
    .light(light), .gnt(gnt), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       tck;
    logic [3:0] rq;
    logic       em;
    logic [1:0] id;
    int         n;
    logic [1:0] ph;
    logic [1:0] cu;
  } seg_t;

  typedef struct {
    logic [1:0]  ph;
    logic [3:0]  g;
    logic [11:0] l;
    int          tag;
  } exp_t;

  seg_t tbl[$];
  exp_t sb[$];
  int   errs = 0;
  int   checks = 0;

  function automatic exp_t mk_exp(input logic [1:0] ph, input logic [1:0] cu, input int tag);
    exp_t e;
    e.ph  = ph;
    e.g   = (ph == G) ? (4'b0001 << cu) : 4'b0000;
    e.l   = 12'b100_100_100_100;
    for (int i = 0; i < 4; i++) begin
      if (i == int'(cu)) begin
        if (ph == G)      e.l[3*i +: 3] = 3'b001;
        else if (ph == Y) e.l[3*i +: 3] = 3'b010;
      end
    end
    e.tag = tag;
    return e;
  endfunction

  task automatic add(input logic tck, input logic [3:0] rq, input logic em, input logic [1:0] id,
                     input int n, input logic [1:0] ph, input logic [1:0] cu);
    seg_t s;
    s.rst = 1'b0; s.tck = tck; s.rq = rq; s.em = em; s.id = id; s.n = n; s.ph = ph; s.cu = cu;
    tbl.push_back(s);
  endtask

  task automatic add_rst();
    seg_t s;
    s.rst = 1'b1; s.tck = 1'b0; s.rq = 4'b0; s.em = 1'b0; s.id = 2'd0; s.n = 0; s.ph = AR; s.cu = 2'd0;
    tbl.push_back(s);
  endtask

  // Monitor: one scoreboard entry per clock, sampled 2 time units after the edge.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({phase, gnt, light} !== {e.ph, e.g, e.l}) begin
        errs++;
        $display("FAIL seg%0d: phase=%0d gnt=%b light=%b, want phase=%0d gnt=%b light=%b",
                 e.tag, phase, gnt, light, e.ph, e.g, e.l);
      end
    end
  end

  initial begin
    // A: reset release, no requests -> approach 0 green and held
    add_rst();
    add(1, 4'b0000, 0, 0, 1000, G, 0);
    // B: single side request at minimum green
    add_rst();
    add(1, 4'b0100, 0, 0, 4, G, 0);
    add(1, 4'b0100, 0, 0, 2, Y, 0);
    add(1, 4'b0100, 0, 0, 1, AR, 0);
    add(1, 4'b0100, 0, 0, 3, G, 2);
    // C: current approach keeps requesting -> max-out
    add_rst();
    add(1, 4'b0011, 0, 0, 12, G, 0);
    add(1, 4'b0011, 0, 0, 2, Y, 0);
    add(1, 4'b0011, 0, 0, 1, AR, 0);
    add(1, 4'b0011, 0, 0, 3, G, 1);
    // D: all requesting -> full rotation
    add_rst();
    for (int a = 0; a < 4; a++) begin
      add(1, 4'b1111, 0, 0, 12, G, 2'(a));
      add(1, 4'b1111, 0, 0, 2, Y, 2'(a));
      add(1, 4'b1111, 0, 0, 1, AR, 2'(a));
    end
    add(1, 4'b1111, 0, 0, 2, G, 0);
    // E: emergency preempt to 3 at tmr=1, hold while emg, then release
    add_rst();
    add(1, 4'b0111, 0, 0, 2, G, 0);
    add(1, 4'b0111, 1, 3, 2, Y, 0);
    add(1, 4'b0111, 1, 3, 1, AR, 0);
    add(1, 4'b0111, 1, 3, 15, G, 3);
    add(1, 4'b0111, 0, 0, 2, Y, 3);
    add(1, 4'b0111, 0, 0, 1, AR, 3);
    add(1, 4'b0111, 0, 0, 2, G, 0);
    // F: tick gating, emergency overwrites latched next during yellow
    add_rst();
    add(0, 4'b0000, 0, 0, 3, AR, 0);
    add(1, 4'b0000, 0, 0, 1, G, 0);
    add(0, 4'b0010, 0, 0, 5, G, 0);
    add(1, 4'b0010, 0, 0, 3, G, 0);
    add(1, 4'b0010, 0, 0, 2, Y, 0);
    add(1, 4'b0010, 1, 3, 1, AR, 0);
    add(1, 4'b0010, 0, 0, 2, G, 3);
    // G: preempt with tick low, yellow frozen until tick returns
    add_rst();
    add(1, 4'b0000, 0, 0, 2, G, 0);
    add(0, 4'b0000, 1, 1, 1, Y, 0);
    add(0, 4'b0000, 0, 0, 3, Y, 0);
    add(1, 4'b0000, 0, 0, 1, Y, 0);
    add(1, 4'b0000, 0, 0, 1, AR, 0);
    add(1, 4'b0000, 0, 0, 2, G, 1);
    // H: reset asserted mid-yellow, then restart
    add_rst();
    add(1, 4'b0100, 0, 0, 4, G, 0);
    add(1, 4'b0100, 0, 0, 1, Y, 0);
    add_rst();
    add(1, 4'b0000, 0, 0, 2, G, 0);

    @(negedge clk);
    foreach (tbl[s]) begin
      if (tbl[s].rst) begin
        #1;
        rst_n = 1'b0; tick = 1'b0; req = 4'b0; emg = 1'b0; emg_id = 2'd0;
        #1;
        checks++;
        if ({phase, gnt, light} !== {AR, 4'b0000, 12'b100_100_100_100}) begin
          errs++;
          $display("FAIL reset seg%0d: phase=%0d gnt=%b light=%b, want phase=2 gnt=0000 light=100100100100",
                   s, phase, gnt, light);
        end
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        for (int c = 0; c < tbl[s].n; c++) begin
          tick = tbl[s].tck; req = tbl[s].rq; emg = tbl[s].em; emg_id = tbl[s].id;
          sb.push_back(mk_exp(tbl[s].ph, tbl[s].cu, s));
          @(negedge clk);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
